// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: operation and FSM state encodings.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_PUSH  = 2'b10,
      OP_POP   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_e;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   // LOAD/STORE use the request address; PUSH/POP use the stack pointer.
   function automatic logic is_addr_op(input op_e op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // Operations that read data memory and therefore pass through WAIT.
   function automatic logic is_read_op(input op_e op);
      return (op == OP_LOAD) || (op == OP_POP);
   endfunction

endpackage

// File: rtl/lsu_sp_unit.sv
// Stack pointer register with +/-4 update and stack bounds flags.
// Latency: sp updates on the rising edge where inc/dec is high.
// Backpressure: none; inc/dec are single-cycle commands from the parent FSM.
// Ports: clk, reset (sync, active-high), inc, dec, sp, sp_minus4,
//        push_fault, pop_fault.
// Build option: STACK_BOUNDS_CHECK_EN enables the full/empty fault flags;
//               otherwise both flags are 0 and sp wraps modulo 2^32.
module lsu_sp_unit
   import load_store_unit_pkg::*;
#(
   parameter logic [31:0] STACK_BASE  = 32'h0000_0200,
   parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        dec,
   output logic [31:0] sp,
   output logic [31:0] sp_minus4,
   output logic        push_fault,
   output logic        pop_fault
);

`ifdef STACK_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   logic [31:0] sp_q;

   assign sp        = sp_q;
   assign sp_minus4 = sp_q - WORD_BYTES;

   // PUSH writes at sp then bumps it, so sp==LIMIT means no slot remains;
   // POP reads at sp-4, so sp==BASE means nothing to pop.
   assign push_fault = BOUNDS_EN && (sp_q == STACK_LIMIT);
   assign pop_fault  = BOUNDS_EN && (sp_q == STACK_BASE);

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= STACK_BASE;
      end else if (inc) begin
         sp_q <= sp_q + WORD_BYTES;
      end else if (dec) begin
         sp_q <= sp_minus4;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: LOAD/STORE/PUSH/POP to a registered-read data memory.
// Latency: load/pop rspValid 3 cycles after handshake, store/push 2, faults 1.
// Backpressure: reqReady only in IDLE (one op in flight); rspValid is unstallable.
// Ports: clk, reset (sync, active-high); req{Valid,Ready,Op,Addr,Data};
//        rsp{Valid,Data,Err}; mem{Read,Write,Address,DataOut,DataIn}; sp.
// Build option: STACK_BOUNDS_CHECK_EN (see lsu_sp_unit) faults PUSH on a full
//               stack and POP on an empty stack without touching memory.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter logic [31:0] STACK_BASE  = 32'h0000_0200,
   parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic [1:0]  reqOp,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqData,
   output logic        rspValid,
   output logic [31:0] rspData,
   output logic        rspErr,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memAddress,
   output logic [31:0] memDataOut,
   input  logic [31:0] memDataIn,
   output logic [31:0] sp
);

   state_e      state, state_nxt;
   op_e         req_op, op_q;
   logic [29:0] addr_q;          // word address; low bits are known zero once accepted
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        hs;
   logic        req_fault;
   logic        sp_inc, sp_dec;
   logic [31:0] sp_minus4;
   logic        push_fault, pop_fault;

   assign req_op = op_e'(reqOp);
   assign hs     = reqValid && (state == S_IDLE);

   assign req_fault = (is_addr_op(req_op) && (reqAddr[1:0] != 2'b00))
                   || ((req_op == OP_PUSH) && push_fault)
                   || ((req_op == OP_POP)  && pop_fault);

   lsu_sp_unit #(
      .STACK_BASE (STACK_BASE),
      .STACK_LIMIT(STACK_LIMIT)
   ) u_sp (
      .clk       (clk),
      .reset     (reset),
      .inc       (sp_inc),
      .dec       (sp_dec),
      .sp        (sp),
      .sp_minus4 (sp_minus4),
      .push_fault(push_fault),
      .pop_fault (pop_fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         op_q    <= OP_LOAD;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            op_q    <= req_op;
            addr_q  <= reqAddr[31:2];
            wdata_q <= reqData;
            err_q   <= req_fault;
            rdata_q <= '0;       // stores, pushes and faults respond with 0
         end else if (state == S_WAIT) begin
            rdata_q <= memDataIn;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      reqReady   = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      memAddress = '0;
      memDataOut = '0;
      sp_inc     = 1'b0;
      sp_dec     = 1'b0;
      rspValid   = 1'b0;
      rspErr     = 1'b0;
      rspData    = '0;
      case (state)
         S_IDLE: begin
            reqReady = 1'b1;
            if (reqValid) begin
               state_nxt = req_fault ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            memDataOut = wdata_q;
            case (op_q)
               OP_LOAD: begin
                  memRead    = 1'b1;
                  memAddress = {addr_q, 2'b00};
               end
               OP_STORE: begin
                  memWrite   = 1'b1;
                  memAddress = {addr_q, 2'b00};
               end
               OP_PUSH: begin
                  memWrite   = 1'b1;
                  memAddress = sp;
                  sp_inc     = 1'b1;
               end
               default: begin    // OP_POP
                  memRead    = 1'b1;
                  memAddress = sp_minus4;
                  sp_dec     = 1'b1;
               end
            endcase
            state_nxt = is_read_op(op_q) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            state_nxt = S_RESP;
         end
         default: begin          // S_RESP
            rspValid  = 1'b1;
            rspErr    = err_q;
            rspData   = rdata_q;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: scoreboard of expected responses and memory
// accesses, filled from a behavioural model at each handshake and drained by
// an independent negedge monitor.
module tb_load_store_unit;

   localparam logic [31:0] BASE  = 32'h0000_0200;
   localparam logic [31:0] LIMIT = 32'h0000_0400;
   localparam logic [1:0]  LOAD  = 2'd0;
   localparam logic [1:0]  STORE = 2'd1;
   localparam logic [1:0]  PUSH  = 2'd2;
   localparam logic [1:0]  POP   = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic [1:0]  reqOp = 2'd0;
   logic [31:0] reqAddr = '0;
   logic [31:0] reqData = '0;
   logic        rspValid;
   logic [31:0] rspData;
   logic        rspErr;
   logic        memRead, memWrite;
   logic [31:0] memAddress, memDataOut;
   logic [31:0] memDataIn = '0;
   logic [31:0] sp;

   load_store_unit #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
      .reqAddr(reqAddr), .reqData(reqData),
      .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
      .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
      .memDataOut(memDataOut), .memDataIn(memDataIn), .sp(sp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] data;
      logic [31:0] sp;
      int          lat;
      int          hs;
   } rsp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   rsp_t        rsp_q[$];
   acc_t        acc_q[$];
   logic [31:0] dmem[logic [31:0]];     // the memory the DUT talks to
   logic [31:0] ref_mem[logic [31:0]];  // the model's view of memory
   logic [31:0] msp;
   int          cycle = 0;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   always @(posedge clk) cycle++;

   // Registered-read data memory; garbage on non-read cycles catches capture slips.
   always @(posedge clk) begin
      if (memWrite) dmem[memAddress] = memDataOut;
      memDataIn <= memRead ? (dmem.exists(memAddress) ? dmem[memAddress] : 32'h0)
                           : $urandom;
   end

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   // Behavioural model: what one request should do, evaluated at its handshake.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int hc);
      rsp_t r;
      acc_t m;
      logic fault;
      fault = (op == LOAD || op == STORE) && (a % 4 != 0);
`ifdef STACK_BOUNDS_CHECK_EN
      if (op == PUSH && msp == LIMIT) fault = 1'b1;
      if (op == POP  && msp == BASE)  fault = 1'b1;
`endif
      r.hs = hc;
      r.err = fault;
      r.data = 32'h0;
      m.data = d;
      if (fault) begin
         r.lat = 1;
      end else begin
         case (op)
            LOAD:  begin m.wr = 1'b0; m.addr = a;   r.data = ref_rd(a); r.lat = 3; end
            STORE: begin m.wr = 1'b1; m.addr = a;   ref_mem[a] = d;     r.lat = 2; end
            PUSH:  begin m.wr = 1'b1; m.addr = msp; ref_mem[msp] = d; msp = msp + 4; r.lat = 2; end
            default: begin msp = msp - 4; m.wr = 1'b0; m.addr = msp; r.data = ref_rd(msp); r.lat = 3; end
         endcase
         acc_q.push_back(m);
      end
      r.sp = msp;
      rsp_q.push_back(r);
   endtask

   // Monitor: every strobe and every response must match the head of its queue.
   always @(negedge clk) begin
      if (!reset) begin
         check("strobe_exclusive", {31'b0, memRead & memWrite}, 32'h0);
         if (memRead || memWrite) begin
            if (acc_q.size() == 0) begin
               check("spurious_strobe", {31'b0, memWrite}, {31'b0, ~memRead});
               check("spurious_strobe_present", 32'h1, 32'h0 + acc_q.size());
            end else begin
               acc_t m;
               m = acc_q.pop_front();
               check("mem_write", {31'b0, memWrite}, {31'b0, m.wr});
               check("mem_read",  {31'b0, memRead},  {31'b0, ~m.wr});
               check("mem_addr", memAddress, m.addr);
               check("mem_dout", memDataOut, m.data);
            end
         end else begin
            check("dout_idle_zero", memDataOut, 32'h0);
         end
         if (rspValid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp", 32'h1, 32'h0 + rsp_q.size());
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               check("rsp_err", {31'b0, rspErr}, {31'b0, r.err});
               check("rsp_data", rspData, r.data);
               check("rsp_sp", sp, r.sp);
               check("rsp_latency", cycle - r.hs, r.lat);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      bit ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         reqValid = 1'b1; reqOp = op; reqAddr = a; reqData = d;
         if (reqReady) ok = 1'b1;
      end
      if (!ok) check("handshake_timeout", 32'h0, 32'h1);
      else     model(op, a, d, cycle);
      @(posedge clk);
      #1 reqValid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && rsp_q.size() != 0; t++) @(negedge clk);
      check("drain_rsp", rsp_q.size(), 32'h0);
      check("drain_acc", acc_q.size(), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      reqValid = 1'b0;
      rsp_q.delete();
      acc_q.delete();
      msp = BASE;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      do_reset();
      @(negedge clk);
      check("reset_ready", {31'b0, reqReady}, 32'h1);
      check("reset_rspvalid", {31'b0, rspValid}, 32'h0);
      check("reset_rsperr", {31'b0, rspErr}, 32'h0);
      check("reset_rspdata", rspData, 32'h0);
      check("reset_strobes", {30'b0, memRead, memWrite}, 32'h0);
      check("reset_memaddr", memAddress, 32'h0);
      check("reset_memdout", memDataOut, 32'h0);
      check("reset_sp", sp, BASE);

      // Directed: store/load round trip, stack LIFO, misaligned load.
      issue(STORE, 32'h10, 32'hDEAD_BEEF);
      issue(LOAD,  32'h10, 32'h0);
      drain();
      issue(PUSH, 32'h0, 32'h11);
      issue(PUSH, 32'h0, 32'h22);
      issue(POP,  32'h0, 32'h0);
      issue(POP,  32'h0, 32'h0);
      drain();
      check("stack_balanced_sp", sp, 32'h200);
      issue(LOAD, 32'h13, 32'h0);
      drain();

      // Randomised mix.
      for (int i = 0; i < 300; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = 32'h1000 + 4 * $urandom_range(0, 7);
         if ($urandom_range(0, 4) == 0) a = a + $urandom_range(1, 3);
         issue(op, a, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      drain();

`ifdef STACK_BOUNDS_CHECK_EN
      do_reset();
      issue(POP, 32'h0, 32'h0);
      drain();
      check("empty_pop_sp", sp, BASE);
      for (int i = 0; i < 129; i++) issue(PUSH, 32'h0, $urandom);
      drain();
      check("full_push_sp", sp, LIMIT);
`endif

      // Reset during WAIT of a LOAD: no response, ready next cycle, sp at base.
      do_reset();
      issue(PUSH, 32'h0, 32'h77);
      drain();
      issue(LOAD, 32'h1000, 32'h0);   // returns in ISSUE
      @(posedge clk);                  // now in WAIT
      #1 reset = 1'b1;
      rsp_q.delete();
      acc_q.delete();
      msp = BASE;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_load_ready", {31'b0, reqReady}, 32'h1);
      check("abort_load_sp", sp, BASE);
      repeat (5) @(negedge clk);

      // Reset during ISSUE of a PUSH: sp must not move.
      issue(PUSH, 32'h0, 32'h55);      // returns in ISSUE
      reset = 1'b1;
      rsp_q.delete();
      acc_q.delete();
      msp = BASE;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_push_ready", {31'b0, reqReady}, 32'h1);
      check("abort_push_sp", sp, BASE);
      repeat (5) @(negedge clk);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter STACK_BASE, 32'h0000_0200, reset value of sp and lowest legal stack address.
REQ-002 SHALL have parameter STACK_LIMIT, 32'h0000_0400, sp value at which the stack is full.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- reqValid  in  1  pipeline request present.
- reqReady  out  1  unit can accept a request.
- reqOp  in  2  operation: 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
- reqAddr  in  32  byte address for LOAD/STORE; ignored for PUSH/POP.
- reqData  in  32  store/push data.
- rspValid  out  1  one-cycle completion pulse.
- rspData  out  32  load/pop result, else 0.
- rspErr  out  1  request faulted, qualified by rspValid.
- memRead  out  1  data-memory read strobe.
- memWrite  out  1  data-memory write strobe.
- memAddress  out  32  byte address to data memory, always word-aligned.
- memDataOut  out  32  write data to data memory.
- memDataIn  in  32  registered read data from data memory, valid the cycle after a memRead edge.
- sp  out  32  current stack pointer, byte address.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-005 SHALL assert reqReady only in IDLE; a handshake is reqValid & reqReady at a rising edge, which latches reqOp, reqAddr and reqData.
REQ-006 SHALL move IDLE->ISSUE on a legal handshake and IDLE->RESP on a faulting handshake (no memory access).
REQ-007 SHALL, in ISSUE, drive memRead=1 for LOAD/POP and memWrite=1 for STORE/PUSH, each for exactly one cycle.
REQ-008 SHALL go ISSUE->WAIT for LOAD/POP and ISSUE->RESP for STORE/PUSH; WAIT->RESP after one cycle, capturing memDataIn into rspData at the WAIT->RESP edge.
REQ-009 SHALL pulse rspValid for exactly one cycle in RESP, then return to IDLE; rspValid has no backpressure.
REQ-010 SHALL give load/pop latency of handshake edge + 3 cycles to rspValid, and store/push latency of + 2 cycles.
REQ-011 SHALL drive memAddress = latched reqAddr for LOAD/STORE, sp for PUSH, and sp-4 for POP.
REQ-012 SHALL update sp: sp+4 at the ISSUE->RESP edge of PUSH, and sp-4 at the ISSUE->WAIT edge of POP; sp arithmetic is modulo 2^32.
REQ-013 SHALL flag a LOAD/STORE with reqAddr[1:0]!=0 as misaligned: rspErr=1, rspData=0, no strobe.
REQ-014 SHALL drive memDataOut = latched reqData during ISSUE and 0 otherwise; strobes SHALL be 0 outside ISSUE.
REQ-015 SHALL never assert memRead and memWrite in the same cycle.
REQ-016 SHALL hold rspData at 0 for STORE, PUSH and faulted responses.

Reset
REQ-017 SHALL, on reset high at a rising edge, set state=IDLE, sp=STACK_BASE, rspValid=0, rspErr=0, rspData=0, memRead=0, memWrite=0, memAddress=0, memDataOut=0, and reqReady=1 in the following cycle.
REQ-018 SHALL abort any in-flight operation on reset mid-operation without producing rspValid; a PUSH/POP aborted before its sp-update edge SHALL leave sp=STACK_BASE.

Configuration
REQ-019 SHALL, with STACK_BOUNDS_CHECK_EN defined, fault a PUSH when sp==STACK_LIMIT and a POP when sp==STACK_BASE: rspErr=1, no strobe, sp unchanged, response via IDLE->RESP.
REQ-020 SHALL, without STACK_BOUNDS_CHECK_EN, perform no stack bounds check; sp wraps freely and PUSH/POP never fault.

Structure
REQ-021 SHALL take op encodings (LOAD/STORE/PUSH/POP) and FSM state encodings from the shared constants include used by the datapath.
REQ-022 SHALL keep the stack pointer register, its ±4 update and its bounds compare in the sub-module lsu_sp_unit; all remaining logic is flat.

Verification
REQ-023 Reset, then STORE addr 0x10, data 0xDEADBEEF -> memWrite=1 one cycle with memAddress=0x10; rspValid 2 cycles after the handshake with rspErr=0.
REQ-024 Then LOAD addr 0x10 -> memRead=1 one cycle; rspValid 3 cycles after the handshake with rspData=0xDEADBEEF.
REQ-025 PUSH 0x11, PUSH 0x22, POP, POP -> writes at 0x200 and 0x204; pops return 0x22 then 0x11; sp ends at 0x200.
REQ-026 LOAD addr 0x13 -> no strobe; rspValid 1 cycle after the handshake with rspErr=1 and rspData=0.
REQ-027 STACK_BOUNDS_CHECK_EN defined: POP at reset -> rspErr=1 and sp=0x200; 128 PUSHes then one more PUSH -> 129th gives rspErr=1 with sp=0x400.
REQ-028 Reset asserted during WAIT of a LOAD -> no rspValid, reqReady=1 in the next cycle, and sp=0x200.
